// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side byte packer: FSM encoding and
// lane/keep helpers.
package fifo_rd_packer_pkg;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_FLUSH_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH_EMIT = 2'd2;

    localparam int MAX_BYTES = 64;

    // Lane counter must hold 0..BYTES inclusive.
    function automatic int lane_w(input int bytes);
        return $clog2(bytes + 1);
    endfunction

    function automatic logic [MAX_BYTES-1:0] keep_mask(input int lanes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < lanes) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a 1-cycle-latency FIFO and packs them little-endian into
// BYTES-wide words on a valid/ready stream; flush emits a partial word.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 r_clk,
    input  logic                 rst,
    input  logic                 empty,
    output logic                 ren,
    input  logic [7:0]           rd_data,
    input  logic                 flush,
    output logic [8*BYTES-1:0]   m_data,
    output logic [BYTES-1:0]     m_keep,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     word_count
);

    localparam int              LW   = lane_w(BYTES);
    localparam logic [LW-1:0]   FULL = LW'(BYTES);

    logic [1:0]          state_q, state_d;
    logic [LW-1:0]       lanes_q, lanes_d, wr_idx;
    logic                rd_pend_q;
    logic [8*BYTES-1:0]  acc_q, acc_d, part_data;
    logic [BYTES-1:0]    part_keep;
    logic [8*BYTES-1:0]  m_data_q;
    logic [BYTES-1:0]    m_keep_q;
    logic                m_valid_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                out_free, move, emit, room, ren_c;

    always_comb begin
        out_free  = !m_valid_q || m_ready;
        move      = (lanes_q == FULL) && out_free;
        room      = ({1'b0, lanes_q} + {{LW{1'b0}}, rd_pend_q}) < {1'b0, FULL};
        // Reading again on a move keeps the stream at one byte per cycle.
        ren_c     = !rst && (state_q == ST_RUN) && !empty && (room || move);
        emit      = (state_q == ST_FLUSH_EMIT) && out_free;
        wr_idx    = move ? '0 : lanes_q;
        lanes_d   = ((move || emit) ? '0 : lanes_q) + LW'(rd_pend_q);
        part_keep = BYTES'(keep_mask(int'(lanes_q)));
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign acc_d[8*gi +: 8]     = (rd_pend_q && (wr_idx == LW'(gi))) ? rd_data
                                                                             : acc_q[8*gi +: 8];
            assign part_data[8*gi +: 8] = part_keep[gi] ? acc_q[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                // Let the in-flight byte land and any full word move out first.
                if (!rd_pend_q && (lanes_q != FULL)) begin
                    state_d = (lanes_q == '0) ? ST_RUN : ST_FLUSH_EMIT;
                end
            end
            ST_FLUSH_EMIT: begin
                if (out_free) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            lanes_q   <= '0;
            rd_pend_q <= 1'b0;
            acc_q     <= '0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            lanes_q   <= lanes_d;
            rd_pend_q <= ren_c;
            acc_q     <= acc_d;
            if (move) begin
                m_data_q  <= acc_q;
                m_keep_q  <= '1;
                m_valid_q <= 1'b1;
            end else if (emit) begin
                m_data_q  <= part_data;
                m_keep_q  <= part_keep;
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (m_valid_q && m_ready) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign ren        = ren_c;
    assign m_data     = m_data_q;
    assign m_keep     = m_keep_q;
    assign m_valid    = m_valid_q;
    assign busy       = (state_q == ST_FLUSH_WAIT) || (state_q == ST_FLUSH_EMIT);
    assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model with 1-cycle read latency, stream
// monitor, directed scenarios and a randomized flush/backpressure run.
module tb_fifo_rd_packer;

    localparam int BYTES = 4;
    localparam int CNT_W = 16;

    logic               r_clk = 1'b0;
    logic               rst;
    logic               empty;
    logic               ren;
    logic [7:0]         rd_data;
    logic               flush;
    logic [8*BYTES-1:0] m_data;
    logic [BYTES-1:0]   m_keep;
    logic               m_valid;
    logic               m_ready;
    logic               busy;
    logic [CNT_W-1:0]   word_count;

    always #5 r_clk = ~r_clk;

    fifo_rd_packer #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
        .r_clk(r_clk), .rst(rst), .empty(empty), .ren(ren), .rd_data(rd_data),
        .flush(flush), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .word_count(word_count)
    );

    // FIFO model: pushed by the stimulus, popped with one cycle of read latency.
    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       hold_empty;

    assign empty = hold_empty || (wr_ptr == rd_ptr);

    always @(posedge r_clk) begin
        if (ren && !empty) begin
            rd_data <= mem[rd_ptr % 1024];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge r_clk) cyc <= cyc + 1;

    int               pops = 0;
    int               ren_cycles = 0;
    int               busy_cycles = 0;
    logic [31:0]      got_data [$];
    logic [3:0]       got_keep [$];
    int               got_cyc [$];

    always @(negedge r_clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_keep.push_back(m_keep);
                got_cyc.push_back(cyc);
                $display("word %0d: data=%h keep=%h cycle=%0d", got_data.size(), m_data, m_keep, cyc);
            end
            if (ren && !empty) pops++;
            if (ren) ren_cycles++;
            if (busy) busy_cycles++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_wc   = 0;

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        wr_ptr++;
    endtask

    task automatic wait_words(input int target);
        for (int k = 0; k < 200 && got_data.size() < target; k++) tick();
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Reference: pop-ordered bytes grouped into BYTES-wide words, with each
    // flush cutting a partial word at the pop count it saw.
    function automatic void build_words(input logic [7:0] bytes[$], input int cuts[$],
                                        output logic [31:0] wd[$], output logic [3:0] wk[$]);
        int          ci;
        int          n;
        logic [31:0] w;
        ci = 0; n = 0; w = '0;
        wd = {}; wk = {};
        for (int i = 0; i <= bytes.size(); i++) begin
            while (ci < cuts.size() && cuts[ci] == i) begin
                if (n > 0) begin
                    wd.push_back(w);
                    wk.push_back(4'((1 << n) - 1));
                    n = 0; w = '0;
                end
                ci++;
            end
            if (i == bytes.size()) break;
            w = w | (32'(bytes[i]) << (8 * n));
            n++;
            if (n == BYTES) begin
                wd.push_back(w);
                wk.push_back(4'hF);
                n = 0; w = '0;
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; m_ready = 1'b1; flush = 1'b0; hold_empty = 1'b0;
        repeat (3) tick();
        n_checks++; if (ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b want 0", ren); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
        n_checks++; if (m_keep !== 4'h0) begin n_fail++; $display("FAIL reset_keep: got %h want 0", m_keep); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (word_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", word_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        int gb = got_data.size();
        int rb = ren_cycles;
        push(8'hAA); push(8'h55); push(8'h12); push(8'h34);
        wait_words(gb + 1);
        n_checks++;
        if (got_data.size() < gb + 1) begin
            n_fail++; $display("FAIL single_timeout: got %0d words want %0d", got_data.size() - gb, 1);
        end else begin
            n_checks++; if (got_data[gb] !== 32'h341255AA) begin n_fail++; $display("FAIL single_data: got %h want 341255aa", got_data[gb]); end
            n_checks++; if (got_keep[gb] !== 4'hF) begin n_fail++; $display("FAIL single_keep: got %h want f", got_keep[gb]); end
        end
        exp_wc += 1;
        repeat (3) tick();
        n_checks++; if (word_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL single_count: got %0d want %0d", word_count, exp_wc); end
        n_checks++; if (ren_cycles - rb !== 4) begin n_fail++; $display("FAIL single_ren_cycles: got %0d want 4", ren_cycles - rb); end
    endtask

    task automatic test_back_to_back();
        int gb = got_data.size();
        int pb = pops;
        int k;
        m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) push(8'(i));
        for (k = 0; k < 50 && !m_valid; k++) tick();
        for (int c = 0; c <= 6; c++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 32'h04030201 || m_keep !== 4'hF) begin
                n_fail++;
                $display("FAIL hold_stable: cycle %0d got valid=%b data=%h keep=%h want 1/04030201/f", c, m_valid, m_data, m_keep);
            end
            if (c < 6) tick();
        end
        n_checks++; if (pops - pb !== 8) begin n_fail++; $display("FAIL stall_pops: got %0d want 8", pops - pb); end
        n_checks++; if (ren !== 1'b0) begin n_fail++; $display("FAIL stall_ren: got %b want 0", ren); end
        m_ready = 1'b1;
        wait_words(gb + 2);
        repeat (3) tick();
        pulse_flush();
        wait_words(gb + 3);
        n_checks++;
        if (got_data.size() < gb + 3) begin
            n_fail++; $display("FAIL b2b_timeout: got %0d words want 3", got_data.size() - gb);
        end else begin
            n_checks++; if (got_data[gb] !== 32'h04030201) begin n_fail++; $display("FAIL b2b_first: got %h want 04030201", got_data[gb]); end
            n_checks++; if (got_data[gb+1] !== 32'h08070605) begin n_fail++; $display("FAIL b2b_second: got %h want 08070605", got_data[gb+1]); end
            n_checks++; if (got_cyc[gb+1] - got_cyc[gb] !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles want 1", got_cyc[gb+1] - got_cyc[gb]); end
            n_checks++; if (got_data[gb+2] !== 32'h00000009 || got_keep[gb+2] !== 4'h1) begin n_fail++; $display("FAIL b2b_tail: got %h/%h want 00000009/1", got_data[gb+2], got_keep[gb+2]); end
        end
        exp_wc += 3;
        repeat (3) tick();
        n_checks++; if (word_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", word_count, exp_wc); end
    endtask

    task automatic test_flush_partial();
        int gb = got_data.size();
        int k;
        push(8'h11); push(8'h22);
        repeat (6) tick();
        pulse_flush();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL partial_busy: got %b want 1", busy); end
        wait_words(gb + 1);
        n_checks++;
        if (got_data.size() < gb + 1) begin
            n_fail++; $display("FAIL partial_timeout: got %0d words want 1", got_data.size() - gb);
        end else begin
            n_checks++; if (got_data[gb] !== 32'h00002211) begin n_fail++; $display("FAIL partial_data: got %h want 00002211", got_data[gb]); end
            n_checks++; if (got_keep[gb] !== 4'h3) begin n_fail++; $display("FAIL partial_keep: got %h want 3", got_keep[gb]); end
        end
        exp_wc += 1;
        for (k = 0; k < 20 && busy; k++) tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL partial_run: busy got %b want 0", busy); end
        n_checks++; if (word_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL partial_count: got %0d want %0d", word_count, exp_wc); end
    endtask

    task automatic test_flush_empty();
        int gb = got_data.size();
        int bb;
        repeat (3) tick();
        bb = busy_cycles;
        pulse_flush();
        repeat (10) tick();
        n_checks++; if (busy_cycles - bb !== 1) begin n_fail++; $display("FAIL empty_busy_cycles: got %0d want 1", busy_cycles - bb); end
        n_checks++; if (got_data.size() !== gb) begin n_fail++; $display("FAIL empty_no_word: got %0d words want 0", got_data.size() - gb); end
    endtask

    task automatic test_random_flush();
        logic [7:0]  sent [$];
        int          cuts [$];
        logic [31:0] wd [$];
        logic [3:0]  wk [$];
        int          gb = got_data.size();
        int          pb = pops;
        int          n, kstart, k;
        bit          flushed;
        logic [7:0]  b;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 11);
            kstart = $urandom_range(0, 8);
            flushed = 1'b0;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                push(b);
                sent.push_back(b);
            end
            for (int c = 0; c < 40; c++) begin
                tick();
                flush = 1'b0;
                m_ready = ($urandom_range(0, 3) != 0);
                hold_empty = ($urandom_range(0, 4) == 0);
                #1;
                // Flush in the very cycle a read is issued; that byte must join the partial.
                if (!flushed && c >= kstart && ren && !empty) begin
                    flush = 1'b1;
                    flushed = 1'b1;
                    @(negedge r_clk);
                    #1;
                    cuts.push_back(pops - pb);
                end
            end
            tick();
            flush = 1'b0; hold_empty = 1'b0; m_ready = 1'b1;
            for (k = 0; k < 100 && (rd_ptr != wr_ptr || busy); k++) tick();
            repeat (3) tick();
            pulse_flush();
            cuts.push_back(pops - pb);
            repeat (6) tick();
        end
        build_words(sent, cuts, wd, wk);
        exp_wc += wd.size();
        n_checks++;
        if (got_data.size() - gb !== wd.size()) begin
            n_fail++; $display("FAIL random_word_count: got %0d words want %0d", got_data.size() - gb, wd.size());
        end else begin
            for (int i = 0; i < wd.size(); i++) begin
                n_checks++;
                if (got_data[gb+i] !== wd[i] || got_keep[gb+i] !== wk[i]) begin
                    n_fail++;
                    $display("FAIL random_word[%0d]: got %h/%h want %h/%h", i, got_data[gb+i], got_keep[gb+i], wd[i], wk[i]);
                end
            end
        end
        n_checks++; if (word_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL random_count: got %0d want %0d", word_count, exp_wc); end
    endtask

    task automatic test_reset_midword();
        int gb;
        hold_empty = 1'b1;
        for (int i = 0; i < 7; i++) push(8'hA0 + 8'(i));
        tick();
        hold_empty = 1'b0;
        repeat (3) tick();
        // Two bytes landed and a third is in flight here.
        rst = 1'b1;
        #1;
        n_checks++; if (ren !== 1'b0) begin n_fail++; $display("FAIL midrst_ren: got %b want 0", ren); end
        tick();
        n_checks++; if (m_valid !== 1'b0 || m_keep !== 4'h0 || m_data !== 32'h0) begin n_fail++; $display("FAIL midrst_out: got %b/%h/%h want 0/0/0", m_valid, m_keep, m_data); end
        n_checks++; if (busy !== 1'b0 || word_count !== 16'h0) begin n_fail++; $display("FAIL midrst_state: busy %b count %0d want 0/0", busy, word_count); end
        gb = got_data.size();
        rst = 1'b0;
        exp_wc = 0;
        wait_words(gb + 1);
        n_checks++;
        if (got_data.size() < gb + 1) begin
            n_fail++; $display("FAIL midrst_timeout: got %0d words want 1", got_data.size() - gb);
        end else begin
            n_checks++; if (got_data[gb] !== 32'hA6A5A4A3 || got_keep[gb] !== 4'hF) begin n_fail++; $display("FAIL midrst_word: got %h/%h want a6a5a4a3/f", got_data[gb], got_keep[gb]); end
        end
        exp_wc += 1;
        repeat (3) tick();
        n_checks++; if (word_count !== 16'(exp_wc)) begin n_fail++; $display("FAIL midrst_count: got %0d want %0d", word_count, exp_wc); end
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1; flush = 1'b0; hold_empty = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_flush_partial();
        test_flush_empty();
        test_random_flush();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
